multicycle_ctrl: RTL

Multi-cycle sequencer for the 16-bit RISC datapath; it replaces the single-cycle control decode with a state machine. It sequences each instruction through fetch, decode, execute, memory and writeback. It handshakes with a shared instruction/data memory port. It traps on illegal opcodes and on memory timeouts.

---
 rtl/gP.sv | 42 ++++
 rtl/ctrl_decode.sv | 35 +++
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gP.sv
// Shared types and encodings for the multi-cycle control sequencer.
package gP;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } ctrl_state_t;

    typedef enum logic [3:0] {
        OP_LW  = 4'h0,
        OP_SW  = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_INV = 4'h4,
        OP_LSL = 4'h5,
        OP_LSR = 4'h6,
        OP_AND = 4'h7,
        OP_OR  = 4'h8,
        OP_SLT = 4'h9,
        OP_BEQ = 4'hB,
        OP_BNE = 4'hC,
        OP_JMP = 4'hD
    } opcode_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; anything outside the opcode map is illegal.
module ctrl_decode
    import gP::*;
(
    input  logic [3:0] opcode_i,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_rtype,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_jmp,
    output logic       is_illegal
);

    always_comb begin
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_rtype   = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_jmp     = 1'b0;
        is_illegal = 1'b0;
        case (opcode_i)
            OP_LW:  is_lw  = 1'b1;
            OP_SW:  is_sw  = 1'b1;
            OP_ADD, OP_SUB, OP_INV, OP_LSL,
            OP_LSR, OP_AND, OP_OR,  OP_SLT: is_rtype = 1'b1;
            OP_BEQ: is_beq = 1'b1;
            OP_BNE: is_bne = 1'b1;
            OP_JMP: is_jmp = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback with
// memory handshake, access timeout and illegal-opcode trap.
module multicycle_ctrl
    import gP::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] OPCODE,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       JMP,
    output logic       BEQ,
    output logic       BNE,
    output logic       MRead,
    output logic       MWrite,
    output logic       ALUsrc,
    output logic       RegDst,
    output logic       M2R,
    output logic       RegWrite,
    output logic [1:0] ALU_OP,
    output logic       InstrDone,
    output logic       Fault,
    output logic [1:0] FaultCode,
    output logic [2:0] State
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    fcode_q, fcode_d;
    logic          is_lw, is_sw, is_rtype, is_beq, is_bne, is_jmp, is_illegal;
    logic          tmo_hit;

    ctrl_decode u_dec (
        .opcode_i  (OPCODE),
        .is_lw     (is_lw),
        .is_sw     (is_sw),
        .is_rtype  (is_rtype),
        .is_beq    (is_beq),
        .is_bne    (is_bne),
        .is_jmp    (is_jmp),
        .is_illegal(is_illegal)
    );

    // A ready in the final allowed wait cycle still completes the access.
    assign tmo_hit   = !MemReady && (cnt_q == TMO_LAST);
    assign FaultCode = fcode_q;
    assign State     = state_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fcode_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcode_q <= fcode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        fcode_d   = fcode_q;
        MemReq    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = PC_SEQ;
        JMP       = 1'b0;
        BEQ       = 1'b0;
        BNE       = 1'b0;
        MRead     = 1'b0;
        MWrite    = 1'b0;
        ALUsrc    = 1'b0;
        RegDst    = 1'b0;
        M2R       = 1'b0;
        RegWrite  = 1'b0;
        ALU_OP    = ALU_ADD;
        InstrDone = 1'b0;
        Fault     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemReq = 1'b1;
                MRead  = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    fcode_d = FC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (is_illegal) begin
                    state_d = S_TRAP;
                    fcode_d = FC_ILLEGAL;
                end else if (is_jmp) begin
                    JMP       = 1'b1;
                    PCWrite   = 1'b1;
                    PCSrc     = PC_JUMP;
                    InstrDone = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_lw || is_sw) begin
                    ALUsrc  = 1'b1;
                    state_d = S_MEM;
                end else if (is_rtype) begin
                    ALU_OP  = ALU_RTYPE;
                    RegDst  = 1'b1;
                    state_d = S_WB;
                end else if (is_beq || is_bne) begin
                    ALU_OP    = ALU_SUB;
                    BEQ       = is_beq;
                    BNE       = is_bne;
                    PCSrc     = PC_BRANCH;
                    PCWrite   = is_beq ? Zero : !Zero;
                    InstrDone = 1'b1;
                end
            end
            S_MEM: begin
                MemReq = 1'b1;
                ALUsrc = 1'b1;
                MRead  = is_lw;
                MWrite = is_sw;
                if (MemReady) begin
                    InstrDone = is_sw;
                    state_d   = is_sw ? S_FETCH : S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    fcode_d = FC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                M2R       = is_lw;
                RegDst    = is_rtype;
                ALU_OP    = is_rtype ? ALU_RTYPE : ALU_ADD;
                state_d   = S_FETCH;
            end
            S_TRAP: Fault = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule
